t5_ifb: RTL and testbench
=========================

T5_IFB -- requirements
Module: t5_ifb

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 clk  input  1  sole clock; all flops rise on posedge clk.
REQ-003 rst  input  1  reset, asynchronous assert, active-low; flops clear while rst=0.
REQ-004 ena  input  1  fetch strobe; idat/pc valid this cycle.
REQ-005 pc  input  XLEN  tagged fetch PC from the fetch stage; pc[1:0]=hart id.
REQ-006 idat  input  XLEN  instruction word returned for pc.
REQ-007 ird  input  1  decode ready; pop head when ival=1.
REQ-008 flush  input  1  kill all instructions of hart fhart.
REQ-009 fhart  input  2  hart id to kill; qualified by flush.
REQ-010 ir  output  XLEN  instruction at buffer head.
REQ-011 irpc  output  XLEN  tagged PC of ir.
REQ-012 ival  output  1  ir/irpc valid for decode.
REQ-013 npc  output  XLEN-2  pc[XLEN-1:2]+1, fall-through fetch address back to the fetch stage.
REQ-014 istl  output  1  stall to the fetch stage; fetch-stage ena SHALL be driven from ~istl.

Function
REQ-015 Storage SHALL be a 2-entry FIFO; each entry holds {pc, idat, kill}; count range 0..2.
REQ-016 Push SHALL occur when ena=1 and istl=0; a push with ena=1 and istl=1 SHALL be dropped.
REQ-017 istl SHALL be registered, equal to 1 exactly when count==2.
REQ-018 ival SHALL be 1 when count>=1 and head kill=0; ir/irpc SHALL show head entry.
REQ-019 Pop SHALL occur when (ival=1 and ird=1) or (count>=1 and head kill=1); killed heads drain one per cycle without ird.
REQ-020 Simultaneous push and pop at count 1 SHALL keep count 1 with the new entry at head; at count 0 a push SHALL give count 1.
REQ-021 flush=1 SHALL set kill on every stored entry with pc[1:0]==fhart in that cycle, and on the entry being pushed if its pc[1:0]==fhart.
REQ-022 Entries of other harts SHALL be unaffected by flush; FIFO order SHALL be preserved.
REQ-023 npc SHALL be combinational from pc, modulo 2^(XLEN-2) (all-ones wraps to 0).
REQ-024 Latency ena-to-ival SHALL be 1 cycle (0 with REQ-030 bypass).

Reset
REQ-025 On rst=0: count=0, istl=0, ival=0, ir=0, irpc=0, all kill bits 0.
REQ-026 Reset mid-operation SHALL discard all entries; first push after rst=1 SHALL be accepted.
REQ-027 npc SHALL track pc during reset (combinational).

Configuration
REQ-028 Macro T5_IFB_BYPASS_EN selects bypass.
REQ-029 Without T5_IFB_BYPASS_EN: ir/irpc/ival driven only from storage; latency 1.
REQ-030 With T5_IFB_BYPASS_EN: when count==0, ena=1 and the incoming word is not killed, ir=idat, irpc=pc, ival=1 same cycle; if ird=1 the word SHALL NOT be stored, else stored as head.

Verification
REQ-031 rst=0 pulse mid-traffic with count=2 -> next cycle count=0, istl=0, ival=0, ir=0.
REQ-032 ird=0, pushes pc=0x100,0x105 -> istl=1 after 2nd push; 3rd push pc=0x10A dropped; ird=1 -> ir order 0x100 then 0x105 tags.
REQ-033 count=2 heads pc=0x101 (hart1), 0x102 (hart2); flush=1,fhart=1 -> hart1 entry drains with ival=0, then irpc=0x102 ival=1.
REQ-034 count=1, ena=1 and ird=1 same cycle -> count stays 1, irpc = new pc next cycle.
REQ-035 pc=0xFFFFFFFC -> npc=0 (XLEN=32); pc=0x00000010 -> npc=0x5.
REQ-036 T5_IFB_BYPASS_EN defined, empty, ena=1, pc=0x200, idat=0x13, ird=1 -> ival=1 ir=0x13 same cycle, count stays 0; undefined -> ival next cycle.

Source files
------------

// File: rtl/t5_ifb.sv
// Two-entry fetch-to-decode instruction buffer with per-hart flush kill.
// Optional macro T5_IFB_BYPASS_EN lets an empty buffer pass the fetch word straight to decode.
module t5_ifb #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] idat,
  input  logic            ird,
  input  logic            flush,
  input  logic [1:0]      fhart,
  output logic [XLEN-1:0] ir,
  output logic [XLEN-1:0] irpc,
  output logic            ival,
  output logic [XLEN-3:0] npc,
  output logic            istl
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] dat;
    logic            kill;
  } ent_t;

  ent_t       ent_q [2];
  ent_t       ent_d [2];
  ent_t       fl    [2];
  ent_t       nw;
  logic [1:0] cnt_q, cnt_d, wr;
  logic       istl_q, istl_d;
  logic       in_kill, ival_st, hkill;
  logic       push, pop, store, byp;

  always_comb begin
    in_kill = flush && (pc[1:0] == fhart);
    hkill   = (cnt_q != 2'd0) && ent_q[0].kill;
    ival_st = (cnt_q != 2'd0) && !ent_q[0].kill;
    push    = ena && !istl_q;
`ifdef T5_IFB_BYPASS_EN
    byp     = (cnt_q == 2'd0) && push && !in_kill;
`else
    byp     = 1'b0;
`endif
    pop     = (ival_st && ird) || hkill;
    store   = push && !(byp && ird);
    nw      = '{pc: pc, dat: idat, kill: in_kill};
    for (int i = 0; i < 2; i++) begin
      fl[i]      = ent_q[i];
      fl[i].kill = ent_q[i].kill ||
                   (flush && (ent_q[i].pc[1:0] == fhart));
    end
    // pop shifts the queue down; the push lands behind what remains
    ent_d[0] = pop ? fl[1] : fl[0];
    ent_d[1] = fl[1];
    wr       = cnt_q - {1'b0, pop};
    if (store) ent_d[wr[0]] = nw;
    cnt_d    = wr + {1'b0, store};
    istl_d   = (cnt_d == 2'd2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      cnt_q    <= 2'd0;
      istl_q   <= 1'b0;
    end else begin
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
      cnt_q    <= cnt_d;
      istl_q   <= istl_d;
    end
  end

  assign ir   = byp ? idat : ent_q[0].dat;
  assign irpc = byp ? pc   : ent_q[0].pc;
  assign ival = ival_st || byp;
  assign istl = istl_q;
  assign npc  = pc[XLEN-1:2] + {{(XLEN-3){1'b0}}, 1'b1};

endmodule

// File: tb/tb_t5_ifb.sv
// Directed bench for t5_ifb: ordering, stall/drop, flush drain,
// push+pop at count 1, async reset, npc wrap and bypass latency.
module tb_t5_ifb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena, ird, flush;
  logic [31:0] pc, idat;
  logic [1:0]  fhart;
  logic [31:0] ir, irpc;
  logic        ival, istl;
  logic [29:0] npc;
  int          errs = 0;
  int          n    = 0;

  t5_ifb #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .ena(ena), .pc(pc), .idat(idat),
    .ird(ird), .flush(flush), .fhart(fhart), .ir(ir),
    .irpc(irpc), .ival(ival), .npc(npc), .istl(istl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic e, input logic [31:0] p,
                     input logic [31:0] d, input logic r);
    ena = e; pc = p; idat = d; ird = r;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; fhart = 2'd0;
    drv(1'b0, 32'h10, 32'h0, 1'b0);
    tick();
    chk("rst_ival", {31'd0, ival}, 32'd0);
    chk("rst_istl", {31'd0, istl}, 32'd0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_irpc", irpc, 32'h0);
    chk("npc_10", {2'b0, npc}, 32'h5);
    pc = 32'hFFFF_FFFC; #1;
    chk("npc_wrap", {2'b0, npc}, 32'h0);
    rst = 1'b1;

    // fill, stall, dropped push, ordered drain
    drv(1'b1, 32'h100, 32'hA0, 1'b0); tick();
    chk("q1_ival", {31'd0, ival}, 32'd1);
    chk("q1_irpc", irpc, 32'h100);
    chk("q1_ir", ir, 32'hA0);
    chk("q1_istl", {31'd0, istl}, 32'd0);
    drv(1'b1, 32'h105, 32'hA1, 1'b0); tick();
    chk("q2_istl", {31'd0, istl}, 32'd1);
    chk("q2_irpc", irpc, 32'h100);
    drv(1'b1, 32'h10A, 32'hA2, 1'b0); tick();
    chk("q3_istl", {31'd0, istl}, 32'd1);
    drv(1'b0, 32'h0, 32'h0, 1'b1); tick();
    chk("q4_irpc", irpc, 32'h105);
    chk("q4_ir", ir, 32'hA1);
    chk("q4_istl", {31'd0, istl}, 32'd0);
    tick();
    chk("q5_ival", {31'd0, ival}, 32'd0);

    // flush hart1 at head, hart2 survives
    drv(1'b1, 32'h101, 32'hB1, 1'b0); tick();
    drv(1'b1, 32'h102, 32'hB2, 1'b0); tick();
    chk("f0_istl", {31'd0, istl}, 32'd1);
    chk("f0_ival", {31'd0, ival}, 32'd1);
    drv(1'b0, 32'h0, 32'h0, 1'b0);
    flush = 1'b1; fhart = 2'd1; tick();
    flush = 1'b0;
    chk("f1_ival", {31'd0, ival}, 32'd0);
    chk("f1_irpc", irpc, 32'h101);
    tick();
    chk("f2_irpc", irpc, 32'h102);
    chk("f2_ival", {31'd0, ival}, 32'd1);
    chk("f2_istl", {31'd0, istl}, 32'd0);

    // push and pop together at count 1
    drv(1'b1, 32'h110, 32'hC0, 1'b1); tick();
    chk("pp_irpc", irpc, 32'h110);
    chk("pp_ir", ir, 32'hC0);
    chk("pp_ival", {31'd0, ival}, 32'd1);
    chk("pp_istl", {31'd0, istl}, 32'd0);
    drv(1'b0, 32'h0, 32'h0, 1'b1); tick();
    chk("pp_empty", {31'd0, ival}, 32'd0);

    // incoming word killed; other hart unaffected
    drv(1'b1, 32'h123, 32'hD3, 1'b0);
    flush = 1'b1; fhart = 2'd3; tick();
    chk("ik_ival", {31'd0, ival}, 32'd0);
    drv(1'b1, 32'h122, 32'hD2, 1'b0); tick();
    flush = 1'b0;
    chk("ik_drain", irpc, 32'h122);
    chk("ik_ival2", {31'd0, ival}, 32'd1);
    drv(1'b0, 32'h0, 32'h0, 1'b1); tick();
    chk("ik_empty", {31'd0, ival}, 32'd0);

    // async reset with a full buffer
    drv(1'b1, 32'h130, 32'hE0, 1'b0); tick();
    drv(1'b1, 32'h131, 32'hE1, 1'b0); tick();
    chk("ar_full", {31'd0, istl}, 32'd1);
    drv(1'b0, 32'h0, 32'h0, 1'b0);
    #2 rst = 1'b0; #1;
    chk("ar_istl", {31'd0, istl}, 32'd0);
    chk("ar_ival", {31'd0, ival}, 32'd0);
    chk("ar_ir", ir, 32'h0);
    #1 rst = 1'b1;
    tick();
    chk("ar_ival2", {31'd0, ival}, 32'd0);
    drv(1'b1, 32'h140, 32'hF0, 1'b0); tick();
    chk("ar_push", irpc, 32'h140);
    chk("ar_pval", {31'd0, ival}, 32'd1);
    drv(1'b0, 32'h0, 32'h0, 1'b1); tick();
    chk("ar_empty", {31'd0, ival}, 32'd0);

    // bypass / latency from empty
    drv(1'b1, 32'h200, 32'h13, 1'b1); #1;
`ifdef T5_IFB_BYPASS_EN
    chk("by_ival", {31'd0, ival}, 32'd1);
    chk("by_ir", ir, 32'h13);
    chk("by_irpc", irpc, 32'h200);
    tick();
    drv(1'b0, 32'h0, 32'h0, 1'b0); #1;
    chk("by_cnt0", {31'd0, ival}, 32'd0);
`else
    chk("nb_ival0", {31'd0, ival}, 32'd0);
    tick();
    drv(1'b0, 32'h0, 32'h0, 1'b0);
    chk("nb_ival1", {31'd0, ival}, 32'd1);
    chk("nb_ir", ir, 32'h13);
`endif

    $display("Result: errors=%0d of %0d checks", errs, n);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
